// File: rtl/frame_pkg.sv
// frame_pkg: shared raster geometry, counter widths and serializer/deserializer state encoding
package frame_pkg;
  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int COL_W = 10;
  localparam int ROW_W = 9;
  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} frame_state_t;
endpackage

// File: rtl/frame_serializer_row_shifter.sv
// row_shifter: active row shift register plus one-row shadow for prefetched data
// Ports: iCLK/iRST_n clock and async active-high reset; load = row_data into shift register,
// capture = row_data into shadow, promote = shadow into shift register, shift = advance one
// column; pixel = current column bit (column 0 first).
module row_shifter
  import frame_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF
) (
  input  logic                iCLK,
  input  logic                iRST_n,
  input  logic                load,
  input  logic                capture,
  input  logic                promote,
  input  logic                shift,
  input  logic [0:H_ACTIVE-1] row_data,
  output logic                pixel
);
  logic [0:H_ACTIVE-1] sr, shadow;
  always_ff @(posedge iCLK or posedge iRST_n)
    if (iRST_n) begin
      sr <= '0;
      shadow <= '0;
    end else begin
      if (load) sr <= row_data;
      else if (promote) sr <= shadow;
      else if (shift) sr <= {sr[1:H_ACTIVE-1], 1'b0};
      if (capture) shadow <= row_data;
    end
  assign pixel = sr[0];
endmodule

// File: rtl/frame_serializer.sv
// frame_serializer: fetches a frame row by row and streams it out one pixel per transfer
// Ports: iCLK/iRST_n clock and async active-high reset; iSTART frame start (IDLE only);
// oBusy/oFinished status; oRowReq/oRowAddr/iRowValid/iRowData row fetch handshake;
// oPixel/oPixelValid/iPixelReady serial pixel handshake.
// FRAME_SERIALIZER_MARKERS_EN adds oSOF (first pixel of frame) and oEOL (last pixel of row).
module frame_serializer
  import frame_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic                iCLK,
  input  logic                iRST_n,
  input  logic                iSTART,
  output logic                oBusy,
  output logic                oFinished,
  output logic                oRowReq,
  output logic [ROW_W-1:0]    oRowAddr,
  input  logic                iRowValid,
  input  logic [0:H_ACTIVE-1] iRowData,
`ifdef FRAME_SERIALIZER_MARKERS_EN
  output logic                oSOF,
  output logic                oEOL,
`endif
  output logic                oPixel,
  output logic                oPixelValid,
  input  logic                iPixelReady
);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_ACTIVE - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_ACTIVE - 1);
  frame_state_t state, state_n;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic shadow_full, col_last, row_last, xfer, load, capture, promote, sr_pixel;
  assign col_last = col == COL_LAST;
  assign row_last = row == ROW_LAST;
  // A row arriving on the same cycle as the last-column transfer goes straight into
  // the shift register, so the shadow never holds a row that is already being shifted.
  always_comb begin
    state_n = state;
    oRowReq = 1'b0;
    oPixelValid = 1'b0;
    oFinished = 1'b0;
    load = 1'b0;
    capture = 1'b0;
    promote = 1'b0;
    case (state)
      IDLE: state_n = iSTART ? FETCH : IDLE;
      FETCH: begin
        oRowReq = 1'b1;
        load = iRowValid;
        state_n = iRowValid ? SHIFT : FETCH;
      end
      SHIFT: begin
        oPixelValid = 1'b1;
        oRowReq = !shadow_full && !row_last;
        if (iPixelReady && col_last) begin
          promote = shadow_full;
          load = oRowReq && iRowValid;
          state_n = row_last ? DONE : (shadow_full || load) ? SHIFT : FETCH;
        end else
          capture = oRowReq && iRowValid;
      end
      DONE: begin
        oFinished = 1'b1;
        state_n = IDLE;
      end
    endcase
  end
  always_ff @(posedge iCLK or posedge iRST_n)
    if (iRST_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge iCLK or posedge iRST_n)
    if (iRST_n) begin
      col <= '0;
      row <= '0;
      shadow_full <= 1'b0;
    end else if (state == IDLE && iSTART) begin
      col <= '0;
      row <= '0;
      shadow_full <= 1'b0;
    end else begin
      if (xfer) col <= col_last ? '0 : col + COL_W'(1);
      if (xfer && col_last && !row_last) row <= row + ROW_W'(1);
      if (capture) shadow_full <= 1'b1;
      else if (promote) shadow_full <= 1'b0;
    end
  assign xfer = oPixelValid && iPixelReady;
  // In SHIFT the only request possible is the prefetch of the next row; it keeps the same
  // address after the row increments and the FSM falls back to FETCH.
  assign oRowAddr = oRowReq ? (state == SHIFT ? row + ROW_W'(1) : row) : '0;
  assign oBusy = state != IDLE;
  assign oPixel = oPixelValid && sr_pixel;
`ifdef FRAME_SERIALIZER_MARKERS_EN
  assign oSOF = oPixelValid && row == '0 && col == '0;
  assign oEOL = oPixelValid && col_last;
`endif
  row_shifter #(.H_ACTIVE(H_ACTIVE)) u_shifter (
    .iCLK(iCLK),
    .iRST_n(iRST_n),
    .load(load),
    .capture(capture),
    .promote(promote),
    .shift(xfer),
    .row_data(iRowData),
    .pixel(sr_pixel)
  );
endmodule

// File: doc/frame_serializer.md
FRAME_SERIALIZER -- requirements
Module: frame_serializer

Interface
REQ-001 Parameter H_ACTIVE, default 640, pixels per row (columns).
REQ-002 Parameter V_ACTIVE, default 480, rows per frame.
REQ-003 iCLK  input  1  clock; all state updates on rising edge.
REQ-004 iRST_n  input  1  reset, asynchronous, active-high.
REQ-005 iSTART  input  1  start-frame pulse; honoured only in IDLE.
REQ-006 oBusy  output  1  high in every state except IDLE.
REQ-007 oFinished  output  1  one-cycle pulse after the last pixel of a frame transfers.
REQ-008 oRowReq  output  1  row fetch request; held until accepted.
REQ-009 oRowAddr  output  9  row index of the pending request, 0..V_ACTIVE-1.
REQ-010 iRowValid  input  1  row data valid; accepted when oRowReq && iRowValid.
REQ-011 iRowData  input  [0:H_ACTIVE-1]  one row of 1-bit pixels; index 0 = column 0.
REQ-012 oPixel  output  1  current serial pixel.
REQ-013 oPixelValid  output  1  oPixel is valid.
REQ-014 iPixelReady  input  1  sink accepts; transfer = oPixelValid && iPixelReady.

Function
REQ-015 States SHALL be IDLE, FETCH, SHIFT, DONE.
REQ-016 IDLE: on iSTART, clear row/column counters and the shadow-full flag, go to FETCH requesting row 0.
REQ-017 FETCH: oRowReq=1, oPixelValid=0; on acceptance, load iRowData into the shift register, column=0, go to SHIFT.
REQ-018 SHIFT: oPixelValid=1, oPixel = shift-register bit for the current column, column 0 first.
REQ-019 oPixel/oPixelValid SHALL remain stable while oPixelValid && !iPixelReady.
REQ-020 On each transfer, shift by one and increment the column; latency from row acceptance to first oPixelValid is 1 cycle.
REQ-021 Prefetch: in SHIFT, with the shadow empty and row+1 < V_ACTIVE, assert oRowReq with oRowAddr=row+1; on acceptance, capture into the shadow and set shadow-full.
REQ-022 On the column H_ACTIVE-1 transfer with shadow-full, in the same cycle copy the shadow into the shift register, clear shadow-full, increment the row, and stay in SHIFT (no bubble).
REQ-023 On the column H_ACTIVE-1 transfer with the shadow empty and row < V_ACTIVE-1, increment the row and go to FETCH; any prefetch request already outstanding stays asserted with the same oRowAddr.
REQ-024 On the column H_ACTIVE-1 transfer of row V_ACTIVE-1, go to DONE; in DONE, oFinished=1 for one cycle, then go to IDLE.
REQ-025 iSTART outside IDLE SHALL be ignored; iRowValid without oRowReq SHALL be ignored.
REQ-026 oRowAddr SHALL not change while oRowReq=1 and the request is not yet accepted.
REQ-027 Counters: column 10 bits, wraps to 0 at H_ACTIVE-1; row 9 bits, never exceeds V_ACTIVE-1.

Reset
REQ-028 Reset SHALL force IDLE; oBusy, oFinished, oRowReq, oPixel, oPixelValid = 0; oRowAddr = 0; counters, shift register and shadow = 0.
REQ-029 Reset mid-frame SHALL abort the frame immediately with no oFinished pulse; the next frame starts only on a new iSTART.

Configuration
REQ-030 With FRAME_SERIALIZER_MARKERS_EN defined, add outputs oSOF (1 on row 0 column 0 while oPixelValid) and oEOL (1 on column H_ACTIVE-1 while oPixelValid), both 0 on reset.
REQ-031 Without FRAME_SERIALIZER_MARKERS_EN, the oSOF/oEOL ports and their logic SHALL not exist; all other behaviour is identical.

Structure
REQ-032 H_ACTIVE/V_ACTIVE defaults, counter widths and the state enum SHALL live in shared package frame_pkg, also used by the deserializer.
REQ-033 Sub-module row_shifter SHALL hold the shift register plus shadow (load, shadow-capture, shadow-promote, shift-on-transfer); the FSM, counters and handshakes SHALL stay in frame_serializer.

Verification
REQ-034 Instant memory (iRowValid=1 every cycle), iPixelReady=1, iSTART -> 307200 consecutive transfers with no bubble after the first; oFinished pulses once, 1 cycle after the final transfer.
REQ-035 Row r = alternating 1010... when r is even, all 1s when r is odd -> serial stream matches bit-for-bit, column 0 first.
REQ-036 iRowValid delayed 700 cycles per request -> oPixelValid=0 during each gap; oRowAddr held stable while pending; no pixel lost or duplicated.
REQ-037 iPixelReady random 30% duty -> oPixel stable while stalled; output equals the reference frame.
REQ-038 iRST_n pulsed at row 100, column 37 -> all outputs 0 on the next edge, no oFinished; a new iSTART restarts from row 0.
REQ-039 iSTART re-pulsed mid-frame -> ignored; with FRAME_SERIALIZER_MARKERS_EN, exactly 1 oSOF and 480 oEOL per frame.
